// File: rtl/loader_pkg.sv
// Shared encodings for the instruction-memory boot loader:
// FSM state values and the byte-lane positions inside a big-endian word.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_e;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes into a big-endian 32-bit word. word is the accumulated
// value including the byte being accepted this cycle, so the caller can latch it.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        clr,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  input  logic        last_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        partial_valid
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] acc_q, acc_d;

  always_comb begin
    word = acc_q;
    case (lane_q)
      LANE0: word[31:24] = byte_in;
      LANE1: word[23:16] = byte_in;
      LANE2: word[15:8]  = byte_in;
      LANE3: word[7:0]   = byte_in;
    endcase
  end

  assign word_valid    = accept && (lane_q == LANE3);
  assign partial_valid = accept && last_in && (lane_q != LANE3);

  // The accumulator restarts at zero for every word, which gives the zero padding.
  always_comb begin
    lane_d = lane_q;
    acc_d  = acc_q;
    if (clear) begin
      lane_d = LANE0;
      acc_d  = '0;
    end else if (accept) begin
      if (word_valid || last_in) begin
        lane_d = LANE0;
        acc_d  = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        acc_d  = word;
      end
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      lane_q <= LANE0;
      acc_q  <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory as big-endian words and
// holds the CPU in reset until the whole image has been written.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_clrn,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic              in_ready_q, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              cpu_clrn_q, done_q, err_q;
  logic [ADDR_W:0]   word_count_q, word_count_d, count_next;

  logic        accept, overflow, pack_accept, start_go;
  logic [31:0] word;
  logic        word_valid, partial_valid;

  // count_next includes a write still in flight, so addressing and the
  // capacity check never lag a back-to-back word.
  assign count_next  = word_count_q + {{ADDR_W{1'b0}}, wr_en_q};
  assign accept      = in_valid && in_ready_q;
  assign overflow    = accept && (count_next == CAP);
  assign pack_accept = accept && !overflow;
  assign start_go    = start && (state_q inside {IDLE, DONE, ERROR});

  byte_packer u_packer (
    .clock         (clock),
    .clr           (clr),
    .clear         (start_go),
    .accept        (pack_accept),
    .byte_in       (in_data),
    .last_in       (in_last),
    .word          (word),
    .word_valid    (word_valid),
    .partial_valid (partial_valid)
  );

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    word_count_d = count_next;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_go) begin
          state_d      = LOAD;
          word_count_d = '0;
        end
      end
      LOAD: begin
        if (overflow) begin
          state_d = ERROR;
        end else if (pack_accept) begin
          if (word_valid || partial_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_next[ADDR_W-1:0];
            wr_data_d = word;
          end
          if (in_last) state_d = partial_valid ? FLUSH : DONE;
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_clrn_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= (state_d == LOAD);
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_clrn_q   <= (state_d == DONE);
      done_q       <= (state_d == DONE);
      err_q        <= (state_d == ERROR);
      word_count_q <= word_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_clrn   = cpu_clrn_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=2): per-cycle vector table plus
// hand sequences for idle, async reset, overflow and full-capacity images.
module tb_imem_loader;

  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          clr, start, in_valid, in_last;
  logic [7:0]    in_data;
  logic          in_ready, wr_en, cpu_clrn, done, err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  imem_loader #(.ADDR_W(AW)) dut (
    .clock      (clock),
    .clr        (clr),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_clrn   (cpu_clrn),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  typedef struct {
    logic          s, v;
    logic [7:0]    d;
    logic          l;
    logic          rdy, wen;
    logic [AW-1:0] addr;
    logic [31:0]   wdat;
    logic          dn, crn, er;
    logic [AW:0]   wc;
  } vec_t;

  vec_t          tbl[$];
  logic [AW-1:0] wq_addr[$];
  logic [31:0]   wq_data[$];

  always @(negedge clock) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  function automatic logic [63:0] outs();
    return {22'd0, in_ready, wr_en, wr_addr, wr_data, done, cpu_clrn, err, word_count};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, v, input logic [7:0] d, input logic l,
                     input logic rdy, wen, input logic [AW-1:0] addr, input logic [31:0] wdat,
                     input logic dn, crn, er, input logic [AW:0] wc);
    tbl.push_back('{s, v, d, l, rdy, wen, addr, wdat, dn, crn, er, wc});
  endtask

  task automatic drive(input logic s, v, input logic [7:0] d, input logic l);
    start = s; in_valid = v; in_data = d; in_last = l;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_write(input string name, input int idx, input logic [AW-1:0] a, input logic [31:0] d);
    if (idx < wq_addr.size()) chk(name, {30'd0, wq_addr[idx], wq_data[idx]}, {30'd0, a, d});
    else chk(name, 64'(wq_addr.size()), 64'(idx + 1));
  endtask

  initial begin
    clr = 1'b1;
    drive(0, 0, 8'h00, 0);
    #12 clr = 1'b0;
    tick();

    // Reset then idle, with stray in_valid ignored.
    chk("reset_outputs", outs(), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'hFF, 1);
      tick();
      chk($sformatf("idle%0d", i), outs(), 64'd0);
    end
    chk("idle_no_write", 64'(wq_addr.size()), 64'd0);

    // Two-word image, then stray byte in DONE.
    add(1,0,8'h00,0, 1,0,0,32'h00000000, 0,0,0,0);
    add(0,1,8'h20,0, 1,0,0,32'h00000000, 0,0,0,0);
    add(0,1,8'h08,0, 1,0,0,32'h00000000, 0,0,0,0);
    add(0,1,8'h00,0, 1,0,0,32'h00000000, 0,0,0,0);
    add(0,1,8'h05,0, 1,1,0,32'h20080005, 0,0,0,0);
    add(0,1,8'h20,0, 1,0,0,32'h20080005, 0,0,0,1);
    add(0,1,8'h09,0, 1,0,0,32'h20080005, 0,0,0,1);
    add(0,1,8'h00,0, 1,0,0,32'h20080005, 0,0,0,1);
    add(0,1,8'h0A,1, 0,1,1,32'h2009000A, 1,1,0,1);
    add(0,0,8'h00,0, 0,0,1,32'h2009000A, 1,1,0,2);
    add(0,1,8'hFF,0, 0,0,1,32'h2009000A, 1,1,0,2);
    // Partial final word flushed with zero padding.
    add(1,0,8'h00,0, 1,0,1,32'h2009000A, 0,0,0,0);
    add(0,1,8'hAC,0, 1,0,1,32'h2009000A, 0,0,0,0);
    add(0,1,8'h01,0, 1,0,1,32'h2009000A, 0,0,0,0);
    add(0,1,8'h02,1, 0,1,0,32'hAC010200, 0,0,0,0);
    add(0,0,8'h00,0, 0,0,0,32'hAC010200, 1,1,0,1);
    // Gapped stream, then start ignored while loading.
    add(1,0,8'h00,0, 1,0,0,32'hAC010200, 0,0,0,0);
    add(0,1,8'h01,0, 1,0,0,32'hAC010200, 0,0,0,0);
    add(0,0,8'h55,0, 1,0,0,32'hAC010200, 0,0,0,0);
    add(0,1,8'h02,0, 1,0,0,32'hAC010200, 0,0,0,0);
    add(0,0,8'h55,0, 1,0,0,32'hAC010200, 0,0,0,0);
    add(0,1,8'h03,0, 1,0,0,32'hAC010200, 0,0,0,0);
    add(0,0,8'h55,0, 1,0,0,32'hAC010200, 0,0,0,0);
    add(0,1,8'h04,0, 1,1,0,32'h01020304, 0,0,0,0);
    add(0,0,8'h00,0, 1,0,0,32'h01020304, 0,0,0,1);
    add(1,0,8'h00,0, 1,0,0,32'h01020304, 0,0,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].l);
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {22'd0, tbl[i].rdy, tbl[i].wen, tbl[i].addr, tbl[i].wdat,
           tbl[i].dn, tbl[i].crn, tbl[i].er, tbl[i].wc});
    end
    chk("table_write_count", 64'(wq_addr.size()), 64'd4);

    // Mid-load async reset after 6 more bytes; restart has no stale bytes.
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 8'hA0 + 8'(i), 0);
      tick();
    end
    drive(0, 0, 8'h00, 0);
    clr = 1'b1;
    #1;
    chk("async_reset", outs(), 64'd0);
    #1 clr = 1'b0;
    tick();
    wq_addr.delete(); wq_data.delete();
    drive(1, 0, 8'h00, 0); tick();
    drive(0, 1, 8'h11, 0); tick();
    drive(0, 1, 8'h22, 0); tick();
    drive(0, 1, 8'h33, 0); tick();
    drive(0, 1, 8'h44, 1); tick();
    drive(0, 0, 8'h00, 0); tick();
    chk("restart_count", 64'(wq_addr.size()), 64'd1);
    chk_write("restart_write", 0, 0, 32'h11223344);
    chk("restart_done", {62'd0, done, cpu_clrn}, 64'd3);

    // Overflow: 17 bytes into a 4-word memory.
    wq_addr.delete(); wq_data.delete();
    drive(1, 0, 8'h00, 0); tick();
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 8'(i), 0);
      tick();
    end
    chk("ovf_flags", {58'd0, in_ready, cpu_clrn, err, done, word_count},
        {58'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4});
    drive(0, 0, 8'h00, 0); tick(); tick();
    chk("ovf_write_count", 64'(wq_addr.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = 8'(4 * k);
      chk_write($sformatf("ovf_write%0d", k), k, AW'(k), {b, b + 8'd1, b + 8'd2, b + 8'd3});
    end
    chk("ovf_hold", {62'd0, err, in_ready}, 64'd2);

    // Reload from ERROR.
    drive(1, 0, 8'h00, 0); tick();
    chk("reload_start", {58'd0, in_ready, err, done, cpu_clrn, word_count}, {58'd0, 4'b1000, 3'd0});
    wq_addr.delete(); wq_data.delete();
    drive(0, 1, 8'hDE, 0); tick();
    drive(0, 1, 8'hAD, 0); tick();
    drive(0, 1, 8'hBE, 0); tick();
    drive(0, 1, 8'hEF, 1); tick();
    drive(0, 0, 8'h00, 0); tick();
    chk_write("reload_write", 0, 0, 32'hDEADBEEF);
    chk("reload_done", {58'd0, done, cpu_clrn, err, 1'b0, word_count}, {58'd0, 4'b1100, 3'd1});

    // Exactly full image ending with in_last is legal.
    wq_addr.delete(); wq_data.delete();
    drive(1, 0, 8'h00, 0); tick();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'h80 + 8'(i), (i == 15));
      tick();
    end
    drive(0, 0, 8'h00, 0); tick();
    chk("full_done", {58'd0, done, cpu_clrn, err, in_ready, word_count}, {58'd0, 4'b1100, 3'd4});
    chk("full_write_count", 64'(wq_addr.size()), 64'd4);
    chk_write("full_last_write", 3, 2'd3, 32'h8C8D8E8F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
